fp_mul_arbiter: RTL and testbench

- Shares one combinational single-precision multiplier (the `multiplier` datapath) between NUM_REQ requesters.
- Per-requester valid/ready request channels; round-robin arbitration.
- Issues operands to the multiplier through registers and holds them stable for MUL_LATENCY cycles.
- Captures the product and returns it with the requester ID on one shared valid/ready response channel.
- Sits between issuing units and the multiplier instance; one operation in flight.

---
 rtl/fp_mul_arbiter_if.sv | 31 +++
 rtl/fp_mul_arbiter.sv | 117 +++++++++++
 tb/tb_fp_mul_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// Bundle of request, multiplier and response signals for fp_mul_arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; the sender holds valid and payload until that edge.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_out;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
  logic                  busy;
  logic [15:0]           op_count;
  logic [1:0]            dbg_state;

  modport slave (
    input  req_valid, req_a, req_b, mul_out, resp_ready,
    output req_ready, mul_a, mul_b, resp_valid, resp_data, resp_id, busy, op_count, dbg_state
  );

  modport master (
    output req_valid, req_a, req_b, mul_out, resp_ready,
    input  req_ready, mul_a, mul_b, resp_valid, resp_data, resp_id, busy, op_count, dbg_state
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one multicycle combinational FP multiplier among NUM_REQ requesters.
// One operation in flight: accept in IDLE, hold operands in WAIT, present the product in RESP.
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  parameter int ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_arbiter_if.slave  bus
);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [15:0]        op_count_q, op_count_d;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    op_count_d  = op_count_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready_c[grant_idx] = 1'b1;
          mul_a_d   = bus.req_a[int'(grant_idx)*32 +: 32];
          mul_b_d   = bus.req_b[int'(grant_idx)*32 +: 32];
          resp_id_d = grant_idx;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d     = CNT_W'(MUL_LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Operands stay frozen so the multiplier path gets MUL_LATENCY full cycles.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_data_d = bus.mul_out;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  // No grant is visible while reset is held, even though the state reads IDLE.
  assign bus.req_ready  = rst_n ? req_ready_c : '0;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = op_count_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed scenarios plus a randomized phase against a transaction-level model.
module tb_fp_mul_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 2;
  localparam int ID_W        = 2;
  localparam int W           = ID_W + 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fp_mul_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MUL_LATENCY(MUL_LATENCY),
    .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Multiplier stub: two known products, anything else a fixed scramble.
  function automatic logic [31:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if (a == 32'h3F80_0000 && b == 32'h4040_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  assign bus.mul_out = mul_stub(bus.mul_a, bus.mul_b);

  int checks = 0;
  int errors = 0;

  logic [31:0]          cur_a [NUM_REQ];
  logic [31:0]          cur_b [NUM_REQ];
  logic                 cur_v [NUM_REQ];
  logic [W-1:0]         exp_q [$];
  int                   model_ptr;
  int                   since;
  logic [15:0]          model_count;
  logic [31:0]          last_a, last_b;
  int                   last_grant;
  logic [NUM_REQ-1:0]   seen_rr;
  int                   cycle;
  int                   grants [$];
  int                   accept_cycles [$];
  int                   waits [NUM_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]         = cur_v[i];
      bus.req_a[32*i +: 32]    = cur_a[i];
      bus.req_b[32*i +: 32]    = cur_b[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cur_v[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    model_ptr   = 0;
    since       = 0;
    model_count = 16'h0000;
    last_a      = 32'h0;
    last_b      = 32'h0;
    last_grant  = -1;
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
  endtask

  // Compare every output against the model for the current cycle, then retire/accept in the model.
  task automatic observe();
    bit     inflight;
    bit     exp_rv;
    int     g;
    int     exp_rr;
    inflight = (exp_q.size() != 0);
    exp_rv   = inflight && (since >= MUL_LATENCY + 1);
    g        = inflight ? -1 : pick();
    exp_rr   = (g >= 0) ? (1 << g) : 0;
    seen_rr  = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
    chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    chk("busy", 64'(bus.busy), 64'(inflight));
    chk("op_count", 64'(bus.op_count), 64'(model_count));
    chk("mul_a", 64'(bus.mul_a), 64'(last_a));
    chk("mul_b", 64'(bus.mul_b), 64'(last_b));
    if (exp_rv) begin
      chk("resp_data", 64'(bus.resp_data), 64'(exp_q[0][31:0]));
      chk("resp_id", 64'(bus.resp_id), 64'(exp_q[0][W-1:32]));
      if (bus.resp_ready) begin
        void'(exp_q.pop_front());
        model_count++;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!cur_v[i]) waits[i] = 0;
      else if (g >= 0) begin
        if (i == g) begin
          chk("fair_wait", 64'(waits[i] <= NUM_REQ - 1), 64'd1);
          waits[i] = 0;
        end else begin
          waits[i]++;
        end
      end
    end
    last_grant = g;
    if (g >= 0) begin
      exp_q.push_back({ID_W'(g), mul_stub(cur_a[g], cur_b[g])});
      last_a    = cur_a[g];
      last_b    = cur_b[g];
      model_ptr = (g + 1) % NUM_REQ;
      since     = 0;
      grants.push_back(g);
      accept_cycles.push_back(cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (exp_q.size() != 0) since++;
  endtask

  task automatic cyc();
    drive();
    #1;
    observe();
    step();
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NUM_REQ; i++) cur_v[i] = 1'b0;
    drive();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_REQ; i++) cur_v[i] = 1'b0;
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc();
    cyc();
  endtask

  task automatic new_ops(input int i);
    cur_a[i] = $urandom;
    cur_b[i] = $urandom;
  endtask

  initial begin
    cycle          = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_v[i] = 1'b0;
      cur_a[i] = 32'h0;
      cur_b[i] = 32'h0;
    end
    drive();
    model_reset();
    #2;
    apply_reset();

    // Single request from requester 1.
    cur_v[1] = 1'b1;
    cur_a[1] = 32'h4000_0000;
    cur_b[1] = 32'h4000_0000;
    cyc();
    chk("single_req_ready", 64'(seen_rr), 64'h2);
    cur_v[1] = 1'b0;
    chk("single_mul_a_0", 64'(bus.mul_a), 64'h4000_0000);
    chk("single_mul_b_0", 64'(bus.mul_b), 64'h4000_0000);
    cyc();
    chk("single_mul_a_1", 64'(bus.mul_a), 64'h4000_0000);
    chk("single_rv_early", 64'(bus.resp_valid), 64'd0);
    cyc();
    chk("single_rv", 64'(bus.resp_valid), 64'd1);
    chk("single_data", 64'(bus.resp_data), 64'h4080_0000);
    chk("single_id", 64'(bus.resp_id), 64'd1);
    bus.resp_ready = 1'b1;
    cyc();
    chk("single_op_count", 64'(bus.op_count), 64'd1);

    // All four requesting continuously from reset.
    apply_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_v[i] = 1'b1;
      new_ops(i);
    end
    grants.delete();
    accept_cycles.delete();
    for (int n = 0; n < 40 && grants.size() < 6; n++) begin
      cyc();
      if (last_grant >= 0) new_ops(last_grant);
    end
    chk("rr_count", 64'(grants.size()), 64'd6);
    if (grants.size() == 6) begin
      chk("rr_g0", 64'(grants[0]), 64'd0);
      chk("rr_g1", 64'(grants[1]), 64'd1);
      chk("rr_g2", 64'(grants[2]), 64'd2);
      chk("rr_g3", 64'(grants[3]), 64'd3);
      chk("rr_g4", 64'(grants[4]), 64'd0);
      chk("rr_g5", 64'(grants[5]), 64'd1);
      for (int k = 1; k < 6; k++)
        chk("rr_spacing", 64'(accept_cycles[k] - accept_cycles[k-1]), 64'(MUL_LATENCY + 2));
    end
    drain();

    // Backpressure: hold the response 10 cycles while another requester waits.
    bus.resp_ready = 1'b0;
    cur_v[2] = 1'b1;
    new_ops(2);
    last_grant = -1;
    for (int n = 0; n < 10 && last_grant < 0; n++) cyc();
    chk("bp_grant", 64'(last_grant), 64'd2);
    begin
      logic [31:0] bp_exp;
      bp_exp   = mul_stub(cur_a[2], cur_b[2]);
      cur_v[2] = 1'b0;
      cur_v[0] = 1'b1;
      new_ops(0);
      for (int n = 0; n < MUL_LATENCY + 1; n++) cyc();
      for (int n = 0; n < 10; n++) begin
        cyc();
        chk("bp_rv", 64'(bus.resp_valid), 64'd1);
        chk("bp_data", 64'(bus.resp_data), 64'(bp_exp));
        chk("bp_id", 64'(bus.resp_id), 64'd2);
        chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      end
    end
    bus.resp_ready = 1'b1;
    cyc();
    chk("bp_idle_busy", 64'(bus.busy), 64'd0);
    chk("bp_idle_state", 64'(bus.dbg_state), 64'd0);
    last_grant = -1;
    for (int n = 0; n < 5 && last_grant < 0; n++) cyc();
    chk("bp_next_grant", 64'(last_grant), 64'd0);
    drain();

    // Reset one cycle into WAIT: the op vanishes.
    cur_v[3] = 1'b1;
    new_ops(3);
    last_grant = -1;
    for (int n = 0; n < 10 && last_grant < 0; n++) cyc();
    chk("mid_grant", 64'(last_grant), 64'd3);
    cur_v[3] = 1'b0;
    cyc();
    apply_reset();
    for (int n = 0; n < MUL_LATENCY + 4; n++) cyc();
    chk("mid_no_resp_op_count", 64'(bus.op_count), 64'd0);

    // op_count wrap, also exercising the second stub product.
    force dut.op_count_q = 16'hFFFF;
    model_count = 16'hFFFF;
    cyc();
    release dut.op_count_q;
    bus.resp_ready = 1'b1;
    cur_v[0] = 1'b1;
    cur_a[0] = 32'h3F80_0000;
    cur_b[0] = 32'h4040_0000;
    last_grant = -1;
    for (int n = 0; n < 10 && last_grant < 0; n++) cyc();
    chk("wrap_grant", 64'(last_grant), 64'd0);
    cur_v[0] = 1'b0;
    chk("wrap_mul_a", 64'(bus.mul_a), 64'h3F80_0000);
    for (int n = 0; n < MUL_LATENCY; n++) cyc();
    chk("wrap_data", 64'(bus.resp_data), 64'h4040_0000);
    drain();
    chk("wrap_op_count", 64'(bus.op_count), 64'h0000);

    // Skip: requester 2 withdraws before its turn.
    grants.delete();
    for (int i = 1; i < NUM_REQ; i++) begin
      cur_v[i] = 1'b1;
      new_ops(i);
    end
    last_grant = -1;
    for (int n = 0; n < 10 && last_grant < 0; n++) cyc();
    cur_v[1] = 1'b0;
    cur_v[2] = 1'b0;
    last_grant = -1;
    for (int n = 0; n < 10 && last_grant < 0; n++) cyc();
    chk("skip_count", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      chk("skip_g0", 64'(grants[0]), 64'd1);
      chk("skip_g1", 64'(grants[1]), 64'd3);
    end
    drain();

    // Randomized traffic with random backpressure and early withdrawals.
    for (int c = 0; c < 400; c++) begin
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_grant == i) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          new_ops(i);
        end else if (!cur_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            cur_v[i] = 1'b1;
            new_ops(i);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          cur_v[i] = 1'b0;
        end
      end
      cyc();
    end
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
